// File: rtl/arv_pkg.sv
// arv_pkg: shared definitions for the arv core front end.
//   fetch_state_e : fetch FSM states (run / flush-after-redirect)
//   WORD_BYTES    : size of one instruction word in bytes
package arv_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    localparam int unsigned WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry synchronous FIFO holding fetched {instr, pc} pairs.
// Ports:
//   clk        clock, all updates on rising edge
//   rst        synchronous active-high reset, also zeroes the storage
//   clear      synchronous flush of the contents (storage data kept)
//   push       write push_data at the tail
//   pop        drop the head entry
//   push_data  entry to write
//   count      number of valid entries (0..2)
//   head_data  oldest entry, stable until popped
module fetch_buffer
    import arv_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the current fill level; a push into a full
    // buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (push && ((count_r != 2'd2) || pop)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop && (count_r != 2'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (clear) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Owns the PC, issues one word read per cycle
// on a fixed 1-cycle-latency memory, buffers up to two returned words and
// hands them to decode over valid/ready. Redirects flush everything in flight.
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   redirect_i/_pc_i        taken control flow from execute (low 2 bits ignored)
//   mem_read_word_en_o      read request this cycle
//   mem_read_word_pos_o     word-aligned byte address of the request
//   mem_read_word_data_i    read data, one cycle after the request
//   id_valid_o/id_ready_i   decode handshake
//   id_instr_o/id_pc_o      instruction word and its address
module ifetch
    import arv_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          MEMWIDTH = 32,
    parameter logic [MEMWIDTH-1:0]  RESET_PC = {MEMWIDTH{1'b0}}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                redirect_i,
    input  logic [MEMWIDTH-1:0] redirect_pc_i,
    output logic                mem_read_word_en_o,
    output logic [MEMWIDTH-1:0] mem_read_word_pos_o,
    input  logic [XLEN-1:0]     mem_read_word_data_i,
    output logic                id_valid_o,
    input  logic                id_ready_i,
    output logic [XLEN-1:0]     id_instr_o,
    output logic [MEMWIDTH-1:0] id_pc_o
);

    localparam int unsigned ENTRY_W = XLEN + MEMWIDTH;

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [MEMWIDTH-1:0]   pc_r;
    logic                  inflight_r;
    logic [MEMWIDTH-1:0]   inflight_pc_r;
    logic [1:0]            count_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [2:0]            occupancy_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  clear_s;
    logic                  issue_s;
    logic                  unused_pc_bits_s;

    // The target's byte offset is deliberately discarded.
    assign unused_pc_bits_s = ^redirect_pc_i[1:0];

    // Handshake, queue control and issue decision.
    always_comb begin
        valid_s     = (count_s != 2'd0) & ~redirect_i;
        pop_s       = valid_s & id_ready_i;
        // Responses arriving in the cycle after a redirect are wrong-path.
        push_s      = (state_r == FETCH_RUN) & inflight_r;
        clear_s     = redirect_i | rst_i;
        // Only issue if the response is guaranteed a slot: entries held plus
        // the one in flight, minus the one leaving now, must stay below 2.
        occupancy_s = {1'b0, count_s} + {2'b00, inflight_r};
        issue_s     = ~rst_i & ~redirect_i & (occupancy_s < (3'd2 + {2'b00, pop_s}));
    end

    // Fetch FSM next state: a redirect always (re)enters FLUSH.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH_RUN: begin
                if (redirect_i) begin
                    state_next_s = FETCH_FLUSH;
                end else begin
                    state_next_s = FETCH_RUN;
                end
            end
            FETCH_FLUSH: begin
                if (redirect_i) begin
                    state_next_s = FETCH_FLUSH;
                end else begin
                    state_next_s = FETCH_RUN;
                end
            end
            default: state_next_s = FETCH_RUN;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= FETCH_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Program counter and in-flight request tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {MEMWIDTH{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
            if (redirect_i) begin
                pc_r <= {redirect_pc_i[MEMWIDTH-1:2], 2'b00};
            end else if (issue_s) begin
                pc_r <= pc_r + MEMWIDTH'(WORD_BYTES);
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    fetch_buffer #(
        .WIDTH (ENTRY_W)
    ) u_fetch_buffer (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data ({mem_read_word_data_i, inflight_pc_r}),
        .count     (count_s),
        .head_data (head_s)
    );

    assign mem_read_word_en_o  = issue_s;
    assign mem_read_word_pos_o = pc_r;
    assign id_valid_o          = valid_s;
    assign id_instr_o          = head_s[ENTRY_W-1:MEMWIDTH];
    assign id_pc_o             = head_s[MEMWIDTH-1:0];

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. A memory responder returns a
// per-address hash one cycle after each request; a reference model (queue of
// buffered {instr,pc}, list of pending requests, next PC) predicts every
// output each cycle. Directed scenarios first, then random traffic.
module tb_ifetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_read_word_en_o;
    logic [31:0] mem_read_word_pos_o;
    logic [31:0] mem_read_word_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;

    always #5 clk_i = ~clk_i;

    ifetch #(
        .XLEN     (32),
        .MEMWIDTH (32),
        .RESET_PC (RPC)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .redirect_i           (redirect_i),
        .redirect_pc_i        (redirect_pc_i),
        .mem_read_word_en_o   (mem_read_word_en_o),
        .mem_read_word_pos_o  (mem_read_word_pos_o),
        .mem_read_word_data_i (mem_read_word_data_i),
        .id_valid_o           (id_valid_o),
        .id_ready_i           (id_ready_i),
        .id_instr_o           (id_instr_o),
        .id_pc_o              (id_pc_o)
    );

    int checks = 0;
    int errors = 0;
    int bad400 = 0;

    // reference model
    logic [63:0] q[$];
    logic [31:0] pend[$];
    logic [31:0] mpc;

    // outputs sampled in the last step
    logic        s_en;
    logic        s_valid;
    logic [31:0] s_pos;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check, advance model at posedge,
    // then present the memory response for whatever the DUT requested.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rst_v);
        int          cnt;
        int          infl;
        int          popv;
        logic        e_valid;
        logic        e_en;
        logic [63:0] head;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        rst_i         = rst_v;
        #1;
        cnt     = q.size();
        infl    = pend.size();
        e_valid = (cnt != 0) && !redir;
        popv    = (e_valid && rdy) ? 1 : 0;
        e_en    = !rst_v && !redir && ((cnt + infl - popv) < 2);
        s_en    = mem_read_word_en_o;
        s_pos   = mem_read_word_pos_o;
        s_valid = id_valid_o;
        s_pc    = id_pc_o;
        s_instr = id_instr_o;
        chk("en", {31'b0, s_en}, {31'b0, e_en});
        chk("pos", s_pos, mpc);
        chk("valid", {31'b0, s_valid}, {31'b0, e_valid});
        if (e_valid) begin
            head = q[0];
            chk("instr", s_instr, head[63:32]);
            chk("id_pc", s_pc, head[31:0]);
        end
        if (s_valid && rdy && s_pc == 32'h0000_0400) bad400++;
        @(posedge clk_i);
        if (rst_v) begin
            mpc = RPC;
            q.delete();
            pend.delete();
        end else if (redir) begin
            mpc = {rpc[31:2], 2'b00};
            q.delete();
            pend.delete();
        end else begin
            if (popv != 0) void'(q.pop_front());
            if (pend.size() > 0) begin
                q.push_back({memf(pend[0]), pend[0]});
                pend.delete();
            end
            if (e_en) begin
                pend.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        #1;
        mem_read_word_data_i = s_en ? memf(s_pos) : $urandom();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i                = 1'b1;
        redirect_i           = 1'b0;
        redirect_pc_i        = 32'h0;
        id_ready_i           = 1'b0;
        mem_read_word_data_i = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        mpc = RPC;
        q.delete();
        pend.delete();
        // reset values
        chk("rst_en", {31'b0, mem_read_word_en_o}, 32'd0);
        chk("rst_pos", mem_read_word_pos_o, RPC);
        chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
        chk("rst_id_pc", id_pc_o, 32'h0);
        chk("rst_instr", id_instr_o, 32'h0);

        // reset release, ready held high
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("c0_en", {31'b0, s_en}, 32'd1);
        chk("c0_pos", s_pos, 32'h100);
        chk("c0_id_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("c1_pos", s_pos, 32'h104);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("c2_pos", s_pos, 32'h108);
        chk("c2_valid", {31'b0, s_valid}, 32'd1);
        chk("c2_id_pc", s_pc, 32'h100);
        chk("c2_instr", s_instr, memf(32'h100));
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("c3_id_pc", s_pc, 32'h104);
        chk("c3_instr", s_instr, memf(32'h104));
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

        // stall from cycle 2 to cycle 10
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_en", {31'b0, s_en}, 32'd0);
        chk("stall_hold_pc", s_pc, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pc0", s_pc, 32'h100);
        chk("resume_en", {31'b0, s_en}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pc1", s_pc, 32'h104);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pc2", s_pc, 32'h108);

        // redirect with data in flight
        step(1'b1, 1'b1, 32'h0000_2002, 1'b0);
        chk("redir_valid_n", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_pos_n1", s_pos, 32'h2000);
        chk("redir_en_n1", {31'b0, s_en}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_valid_n2", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("redir_id_pc_n3", s_pc, 32'h2000);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);

        // back-to-back redirects
        step(1'b1, 1'b1, 32'h0000_0400, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0800, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("b2b_pos", s_pos, 32'h800);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("b2b_id_pc", s_pc, 32'h800);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

        // PC wrap
        step(1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_pos0", s_pos, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_pos1", s_pos, 32'h0000_0000);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

        // reset mid-stream with a full queue
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mrst_valid", {31'b0, s_valid}, 32'd0);
        chk("mrst_pos", s_pos, RPC);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mrst_valid1", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("mrst_id_pc", s_pc, RPC);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 $urandom(),
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        chk("no_0x400_delivered", bad400, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
